// File: rtl/cmsdk_ahb_cmd_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined SINGLE
// transfers and returns one in-order response (read data, error) per command.
module cmsdk_ahb_cmd_master #(
  parameter int          AW        = 32,
  parameter int          DW        = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_write_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [2:0]    cmd_size_i,
  input  logic [DW-1:0] cmd_wdata_i,
  output logic          rsp_valid_o,
  output logic          rsp_write_o,
  output logic          rsp_err_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic [AW-1:0] HADDR_o,
  output logic [1:0]    HTRANS_o,
  output logic          HWRITE_o,
  output logic [2:0]    HSIZE_o,
  output logic [2:0]    HBURST_o,
  output logic [3:0]    HPROT_o,
  output logic          HMASTLOCK_o,
  output logic [DW-1:0] HWDATA_o,
  input  logic          HREADY_i,
  input  logic          HRESP_i,
  input  logic [DW-1:0] HRDATA_i
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic          a_valid_q, a_cancel_q, a_write_q;
  logic [AW-1:0] a_addr_q;
  logic [2:0]    a_size_q;
  logic [DW-1:0] a_wdata_q;
  logic          d_valid_q, d_write_q;
  logic [DW-1:0] d_wdata_q;
  logic          rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [DW-1:0] rsp_rdata_q;

  logic          advance;
  logic          accept;

  assign advance     = HREADY_i & ~a_cancel_q;
  assign cmd_ready_o = advance;
  assign accept      = advance & cmd_valid_i;

  // Address phase; a_cancel masks the pending command for the second ERROR cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid_q  <= 1'b0;
      a_cancel_q <= 1'b0;
      a_write_q  <= 1'b0;
      a_addr_q   <= '0;
      a_size_q   <= '0;
      a_wdata_q  <= '0;
    end else if (HREADY_i) begin
      if (a_cancel_q) begin
        a_cancel_q <= 1'b0;
      end else if (accept) begin
        a_valid_q <= 1'b1;
        a_write_q <= cmd_write_i;
        a_addr_q  <= cmd_addr_i;
        a_size_q  <= cmd_size_i;
        a_wdata_q <= cmd_wdata_i;
      end else begin
        a_valid_q <= 1'b0;
      end
    end else if (d_valid_q && HRESP_i) begin
      a_cancel_q <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
    end else if (HREADY_i) begin
      if (a_cancel_q) begin
        d_valid_q <= 1'b0;
      end else begin
        d_valid_q <= a_valid_q;
        d_write_q <= a_write_q;
        d_wdata_q <= a_wdata_q;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (d_valid_q && HREADY_i) begin
      rsp_valid_q <= 1'b1;
      rsp_write_q <= d_write_q;
      rsp_err_q   <= HRESP_i;
      rsp_rdata_q <= d_write_q ? '0 : HRDATA_i;
    end else begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign HTRANS_o    = (a_valid_q & ~a_cancel_q) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR_o     = a_addr_q;
  assign HWRITE_o    = a_write_q;
  assign HSIZE_o     = a_size_q;
  assign HBURST_o    = 3'b000;
  assign HPROT_o     = HPROT_VAL;
  assign HMASTLOCK_o = 1'b0;
  assign HWDATA_o    = d_wdata_q;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_write_o = rsp_write_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_cmsdk_ahb_cmd_master.sv
// Randomized bench: bench-side AHB slave with wait states and two-cycle ERROR
// responses, plus an in-order command/response reference model.
module tb_cmsdk_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [2:0]  cmd_size_i;
  logic        rsp_valid_o, rsp_write_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] HADDR_o, HWDATA_o, HRDATA_i;
  logic [1:0]  HTRANS_o;
  logic        HWRITE_o, HMASTLOCK_o, HREADY_i, HRESP_i;
  logic [2:0]  HSIZE_o, HBURST_o;
  logic [3:0]  HPROT_o;

  always #5 HCLK = ~HCLK;

  cmsdk_ahb_cmd_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_write_o(rsp_write_o), .rsp_err_o(rsp_err_o),
    .rsp_rdata_o(rsp_rdata_o),
    .HADDR_o(HADDR_o), .HTRANS_o(HTRANS_o), .HWRITE_o(HWRITE_o), .HSIZE_o(HSIZE_o),
    .HBURST_o(HBURST_o), .HPROT_o(HPROT_o), .HMASTLOCK_o(HMASTLOCK_o),
    .HWDATA_o(HWDATA_o), .HREADY_i(HREADY_i), .HRESP_i(HRESP_i), .HRDATA_i(HRDATA_i)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  int checks = 0;
  int failures = 0;

  cmd_t        iss_q[$];
  cmd_t        rsp_q[$];
  cmd_t        cur, dp_cmd, inj_cmd;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  bit          dp_active, dp_err, err_stage, rsp_exp, took, gen_en, inject, force_wait;
  int          dp_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Unwritten locations read back as a fixed function of the address.
  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.w = 1'($urandom_range(0, 1));
    c.a = 32'h2000_0000 | (($urandom_range(0, 4) == 0) ? 32'h1000 : 32'h0)
          | (32'($urandom_range(0, 7)) << 2);
    c.d = $urandom;
    return c;
  endfunction

  task automatic cycle();
    cmd_t        c, e;
    logic        err;
    logic [31:0] exp_rd;
    bit          in_cancel;
    @(negedge HCLK);
    // Response produced by the previous edge
    chk("rsp_valid", rsp_valid_o, rsp_exp);
    if (rsp_valid_o && rsp_exp) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        c   = rsp_q.pop_front();
        err = c.a[12];
        exp_rd = (c.w || err) ? 32'h0
               : (model_mem.exists(c.a) ? model_mem[c.a] : mem_default(c.a));
        if (c.w && !err) model_mem[c.a] = c.d;
        chk("rsp_write", rsp_write_o, c.w);
        chk("rsp_err", rsp_err_o, err);
        chk("rsp_rdata", rsp_rdata_o, exp_rd);
      end
    end
    rsp_exp = 0;

    if (!cmd_valid_i || took) begin
      took = 0;
      if (inject) begin
        cur = inj_cmd; inject = 0; cmd_valid_i = 1'b1;
      end else if (gen_en && $urandom_range(0, 3) != 0) begin
        cur = rand_cmd(); cmd_valid_i = 1'b1;
      end else begin
        cmd_valid_i = 1'b0;
      end
      cmd_write_i = cur.w; cmd_addr_i = cur.a; cmd_wdata_i = cur.d; cmd_size_i = 3'd2;
    end

    in_cancel = 0;
    HREADY_i = 1'b1; HRESP_i = 1'b0; HRDATA_i = 32'h0;
    if (dp_active) begin
      if (dp_err) begin
        HRESP_i = 1'b1;
        if (!err_stage) begin
          HREADY_i = 1'b0; err_stage = 1;
        end else begin
          in_cancel = 1;
        end
      end else if (dp_wait > 0) begin
        HREADY_i = 1'b0; HRDATA_i = $urandom; dp_wait--;
      end else if (!dp_cmd.w) begin
        HRDATA_i = slave_mem.exists(dp_cmd.a) ? slave_mem[dp_cmd.a] : mem_default(dp_cmd.a);
      end
    end
    #1;

    chk("cmd_ready", cmd_ready_o, HREADY_i && !in_cancel);
    if (in_cancel) chk("htrans_err2", HTRANS_o, 2'b00);
    if (!HREADY_i && HTRANS_o == 2'b10 && iss_q.size() > 0)
      chk("haddr_hold", HADDR_o, iss_q[0].a);
    if (HREADY_i) begin
      if (dp_active) begin
        if (dp_cmd.w) chk("hwdata", HWDATA_o, dp_cmd.d);
        if (dp_cmd.w && !dp_err) slave_mem[dp_cmd.a] = HWDATA_o;
        dp_active = 0;
        rsp_exp = 1;
      end
      if (HTRANS_o == 2'b10) begin
        if (iss_q.size() == 0) begin
          chk("nonseq_unexpected", 1, 0);
        end else begin
          e = iss_q.pop_front();
          chk("haddr", HADDR_o, e.a);
          chk("hwrite", HWRITE_o, e.w);
          chk("hsize", HSIZE_o, 3'd2);
          dp_cmd = e; dp_active = 1; dp_err = e.a[12]; err_stage = 0;
          dp_wait = force_wait ? 3 : $urandom_range(0, 2);
        end
      end else if (HTRANS_o != 2'b00) begin
        chk("htrans_legal", HTRANS_o, 2'b00);
      end
    end
    if (cmd_valid_i && cmd_ready_o) begin
      iss_q.push_back(cur);
      rsp_q.push_back(cur);
      took = 1;
    end
  endtask

  initial begin
    int n;
    HRESETn = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_size_i = '0; cmd_wdata_i = '0; HREADY_i = 1'b1; HRESP_i = 1'b0; HRDATA_i = '0;
    gen_en = 0; inject = 0; force_wait = 0; took = 0; rsp_exp = 0; dp_active = 0;
    cur = rand_cmd();
    repeat (2) @(negedge HCLK);
    #1;
    chk("rst_htrans", HTRANS_o, 2'b00);
    chk("rst_haddr", HADDR_o, 32'h0);
    chk("rst_hwrite", HWRITE_o, 1'b0);
    chk("rst_hsize", HSIZE_o, 3'd0);
    chk("rst_hwdata", HWDATA_o, 32'h0);
    chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_write_o, rsp_rdata_o}, 35'h0);
    chk("hburst", HBURST_o, 3'b000);
    chk("hprot", HPROT_o, 4'b0011);
    chk("hmastlock", HMASTLOCK_o, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    gen_en = 1;
    repeat (600) cycle();
    gen_en = 0;
    n = 0;
    while ((cmd_valid_i || iss_q.size() > 0 || rsp_q.size() > 0 || dp_active || rsp_exp)
           && n < 60) begin
      cycle(); n++;
    end
    chk("drain", n < 60, 1'b1);

    // Reset while a read sits in a stretched data phase: no response may follow.
    inj_cmd.w = 1'b0; inj_cmd.a = 32'h4000_0004; inj_cmd.d = '0;
    inject = 1; force_wait = 1;
    n = 0;
    do begin cycle(); n++; end while (!dp_active && n < 10);
    chk("rst_test_dphase", dp_active, 1'b1);
    cycle();
    @(negedge HCLK);
    HRESETn = 1'b0; cmd_valid_i = 1'b0;
    #1;
    chk("midrst_htrans", HTRANS_o, 2'b00);
    chk("midrst_rsp_valid", rsp_valid_o, 1'b0);
    chk("midrst_haddr", HADDR_o, 32'h0);
    iss_q.delete(); rsp_q.delete(); dp_active = 0; rsp_exp = 0; took = 0; force_wait = 0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
